// File: rtl/mi3_pio_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mi3_pio_arbiter_if
// Purpose  : Requester handshakes and PIO slave bus shared by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mi3_pio_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic              grant_id;
    logic [ADDR_W-1:0] pio_address;
    logic              pio_chipselect;
    logic              pio_write_n;
    logic [DATA_W-1:0] pio_writedata;
    logic [DATA_W-1:0] pio_readdata;

    // Arbiter side: accepts requests, drives acks and the PIO bus.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, pio_readdata,
        output ack0, ack1, rdata0, rdata1, busy, grant_id,
               pio_address, pio_chipselect, pio_write_n, pio_writedata
    );

    // Environment side: requesters plus the PIO slave.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, pio_readdata,
        input  ack0, ack1, rdata0, rdata1, busy, grant_id,
               pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
endinterface
`default_nettype wire

// File: rtl/mi3_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mi3_pio_arbiter
// Purpose  : Two-requester round-robin arbiter in front of an Avalon-MM PIO.
// Revision : 1.0 - initial release
// ============================================================================
module mi3_pio_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mi3_pio_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            r_state, w_state;
    logic              r_prio, w_prio;
    logic              r_grant_id, w_grant_id;
    logic              r_cs, w_cs;
    logic              r_write_n, w_write_n;
    logic              r_ack0, w_ack0;
    logic              r_ack1, w_ack1;
    logic [ADDR_W-1:0] r_address, w_address;
    logic [DATA_W-1:0] r_writedata, w_writedata;
    logic [DATA_W-1:0] r_rdata0, w_rdata0;
    logic [DATA_W-1:0] r_rdata1, w_rdata1;

    logic              w_winner;
    logic              w_win_we;

    // A lone requester wins outright; the pointer only breaks ties.
    assign w_winner = (bus.req0 && bus.req1) ? r_prio : bus.req1;
    assign w_win_we = w_winner ? bus.we1 : bus.we0;

    always_comb begin
        w_state     = r_state;
        w_prio      = r_prio;
        w_grant_id  = r_grant_id;
        w_cs        = r_cs;
        w_write_n   = r_write_n;
        w_ack0      = r_ack0;
        w_ack1      = r_ack1;
        w_address   = r_address;
        w_writedata = r_writedata;
        w_rdata0    = r_rdata0;
        w_rdata1    = r_rdata1;
        case (r_state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_state    = ACCESS;
                    w_grant_id = w_winner;
                    w_cs       = 1'b1;
                    w_write_n  = ~w_win_we;
                    w_address  = w_winner ? bus.addr1 : bus.addr0;
                    if (w_win_we) begin
                        w_writedata = w_winner ? bus.wdata1 : bus.wdata0;
                    end
                end
            end
            ACCESS: begin
                // write_n still high means this cycle is a read.
                if (r_write_n) begin
                    if (r_grant_id) begin
                        w_rdata1 = bus.pio_readdata;
                    end else begin
                        w_rdata0 = bus.pio_readdata;
                    end
                end
                w_cs      = 1'b0;
                w_write_n = 1'b1;
                w_ack0    = ~r_grant_id;
                w_ack1    = r_grant_id;
                w_state   = DONE;
            end
            DONE: begin
                w_prio  = ~r_grant_id;
                w_ack0  = 1'b0;
                w_ack1  = 1'b0;
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_grant_id  <= 1'b0;
            r_cs        <= 1'b0;
            r_write_n   <= 1'b1;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state     <= w_state;
            r_prio      <= w_prio;
            r_grant_id  <= w_grant_id;
            r_cs        <= w_cs;
            r_write_n   <= w_write_n;
            r_ack0      <= w_ack0;
            r_ack1      <= w_ack1;
            r_address   <= w_address;
            r_writedata <= w_writedata;
            r_rdata0    <= w_rdata0;
            r_rdata1    <= w_rdata1;
        end
    end

    assign bus.ack0           = r_ack0;
    assign bus.ack1           = r_ack1;
    assign bus.rdata0         = r_rdata0;
    assign bus.rdata1         = r_rdata1;
    assign bus.busy           = (r_state != IDLE);
    assign bus.grant_id       = r_grant_id;
    assign bus.pio_address    = r_address;
    assign bus.pio_chipselect = r_cs;
    assign bus.pio_write_n    = r_write_n;
    assign bus.pio_writedata  = r_writedata;

endmodule
`default_nettype wire

// File: tb/tb_mi3_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mi3_pio_arbiter
// Purpose  : Directed bench with a transaction-timeline model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mi3_pio_arbiter;

    logic clk;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    mi3_pio_arbiter_if #(.DATA_W(32), .ADDR_W(2)) bus ();

    mi3_pio_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave: one output register at word 0, unaffected by arbiter reset.
    logic [31:0] out_port = 32'd0;
    always @(posedge clk) begin
        if (bus.pio_chipselect === 1'b1 && bus.pio_write_n === 1'b0 && bus.pio_address == 2'd0)
            out_port <= bus.pio_writedata;
    end
    assign bus.pio_readdata = (bus.pio_address == 2'd0) ? out_port : 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: each granted transfer is a timeline starting at grant cycle m_t:
    // chipselect in m_t+1, ack in m_t+2, free again from m_t+3.
    bit          m_active = 1'b0;
    int          m_t      = 0;
    bit          m_prio   = 1'b0;
    bit          m_gid    = 1'b0;
    bit          m_we     = 1'b0;
    logic [1:0]  m_addr   = 2'd0;
    logic [31:0] m_wdata  = 32'd0;
    logic [31:0] m_rd0    = 32'd0;
    logic [31:0] m_rd1    = 32'd0;
    logic [31:0] m_port   = 32'd0;
    wire         m_win    = (bus.req0 && bus.req1) ? m_prio : bus.req1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_active && cyc == m_t + 1 && m_we && m_addr == 2'd0)
            m_port <= m_wdata;
        if (reset) begin
            m_active <= 1'b0;
            m_prio   <= 1'b0;
            m_gid    <= 1'b0;
            m_addr   <= 2'd0;
            m_wdata  <= 32'd0;
            m_rd0    <= 32'd0;
            m_rd1    <= 32'd0;
        end else if (m_active) begin
            if (cyc == m_t + 1 && !m_we) begin
                if (m_gid) m_rd1 <= (m_addr == 2'd0) ? m_port : 32'd0;
                else       m_rd0 <= (m_addr == 2'd0) ? m_port : 32'd0;
            end
            if (cyc == m_t + 2) begin
                m_active <= 1'b0;
                m_prio   <= !m_gid;
            end
        end else if (bus.req0 || bus.req1) begin
            m_active <= 1'b1;
            m_t      <= cyc;
            m_gid    <= m_win;
            m_we     <= m_win ? bus.we1 : bus.we0;
            m_addr   <= m_win ? bus.addr1 : bus.addr0;
            if (m_win ? bus.we1 : bus.we0)
                m_wdata <= m_win ? bus.wdata1 : bus.wdata0;
        end
    end

    wire e_cs   = m_active && (cyc == m_t + 1);
    wire e_wn   = !(e_cs && m_we);
    wire e_ack  = m_active && (cyc == m_t + 2);
    wire e_ack0 = e_ack && !m_gid;
    wire e_ack1 = e_ack && m_gid;

    int ack_id_q[$];
    int ack_cyc_q[$];
    bit prev_cs  = 1'b0;
    bit prev2_cs = 1'b0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("chipselect", {31'd0, bus.pio_chipselect}, {31'd0, e_cs});
            chk("write_n",    {31'd0, bus.pio_write_n},    {31'd0, e_wn});
            chk("ack0",       {31'd0, bus.ack0},           {31'd0, e_ack0});
            chk("ack1",       {31'd0, bus.ack1},           {31'd0, e_ack1});
            chk("busy",       {31'd0, bus.busy},           {31'd0, m_active});
            chk("grant_id",   {31'd0, bus.grant_id},       {31'd0, m_gid});
            chk("address",    {30'd0, bus.pio_address},    {30'd0, m_addr});
            chk("writedata",  bus.pio_writedata,           m_wdata);
            chk("rdata0",     bus.rdata0,                  m_rd0);
            chk("rdata1",     bus.rdata1,                  m_rd1);
            chk("cs_twice",   {31'd0, bus.pio_chipselect && prev_cs}, 32'd0);
            chk("ack_both",   {31'd0, bus.ack0 && bus.ack1},          32'd0);
            if (bus.ack0 || bus.ack1)
                chk("ack_after_one_cs", {31'd0, prev_cs && !prev2_cs}, 32'd1);
            if (bus.ack0) begin ack_id_q.push_back(0); ack_cyc_q.push_back(cyc); end
            if (bus.ack1) begin ack_id_q.push_back(1); ack_cyc_q.push_back(cyc); end
        end
        prev2_cs <= prev_cs;
        prev_cs  <= (bus.pio_chipselect === 1'b1);
    end

    task automatic drive(input int id, input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        if (id == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // Holds req across n transfers; each data word is base + k*step.
    task automatic requester(input int id, input int n, input bit w, input logic [1:0] a,
                             input logic [31:0] base, input logic [31:0] step);
        bit got;
        for (int k = 0; k < n; k++) begin
            drive(id, 1'b1, w, a, base + step * k);
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                got = (id == 0) ? bus.ack0 : bus.ack1;
            end
            chk("ack_wait", {31'd0, got}, 32'd1);
            @(posedge clk); #1;
        end
        drive(id, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int base;

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_cs",   {31'd0, bus.pio_chipselect}, 32'd0);
        chk("rst_wn",   {31'd0, bus.pio_write_n},    32'd1);
        chk("rst_busy", {31'd0, bus.busy},           32'd0);

        // Single write with literal timing.
        drive(0, 1'b1, 1'b1, 2'd0, 32'hDEADBEEF);
        @(negedge clk);
        @(negedge clk);
        chk("wr_cs_T1", {31'd0, bus.pio_chipselect}, 32'd1);
        chk("wr_wn_T1", {31'd0, bus.pio_write_n},    32'd0);
        @(negedge clk);
        chk("wr_ack0_T2", {31'd0, bus.ack0}, 32'd1);
        chk("wr_port_T2", out_port, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0);

        // Reads by requester 1 at word 0 and at an unmapped word.
        requester(1, 1, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("rd1_addr0", bus.rdata1, 32'hDEADBEEF);
        requester(1, 1, 1'b0, 2'd2, 32'd0, 32'd0);
        chk("rd1_addr2", bus.rdata1, 32'h00000000);

        // Simultaneous writers from reset alternate 0,1,0,1.
        do_reset();
        base = ack_id_q.size();
        fork
            requester(0, 2, 1'b1, 2'd0, 32'h11111111, 32'd0);
            requester(1, 2, 1'b1, 2'd0, 32'h22222222, 32'd0);
        join
        chk("sim_count", ack_id_q.size() - base, 32'd4);
        if (ack_id_q.size() - base == 4) begin
            chk("sim_order0", ack_id_q[base],     32'd0);
            chk("sim_order1", ack_id_q[base + 1], 32'd1);
            chk("sim_order2", ack_id_q[base + 2], 32'd0);
            chk("sim_order3", ack_id_q[base + 3], 32'd1);
            for (int k = 1; k < 4; k++)
                chk("sim_spacing", ack_cyc_q[base + k] - ack_cyc_q[base + k - 1], 32'd3);
        end
        chk("sim_port", out_port, 32'h22222222);

        // Back-to-back writes 1..4 from requester 0.
        base = ack_id_q.size();
        requester(0, 4, 1'b1, 2'd0, 32'd1, 32'd1);
        chk("b2b_count", ack_id_q.size() - base, 32'd4);
        if (ack_id_q.size() - base == 4)
            for (int k = 1; k < 4; k++)
                chk("b2b_spacing", ack_cyc_q[base + k] - ack_cyc_q[base + k - 1], 32'd3);
        chk("b2b_port", out_port, 32'd4);

        // Reset during the ACCESS cycle of a read.
        requester(0, 1, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("pre_rst_rdata0", bus.rdata0, 32'd4);
        base = ack_id_q.size();
        drive(0, 1'b1, 1'b0, 2'd0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_rdata0", bus.rdata0, 32'd0);
        chk("abort_ack0",   {31'd0, bus.ack0}, 32'd0);
        chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_ack", ack_id_q.size() - base, 32'd0);
        fork
            requester(0, 1, 1'b0, 2'd0, 32'd0, 32'd0);
            requester(1, 1, 1'b0, 2'd3, 32'd0, 32'd0);
        join
        chk("post_rst_count", ack_id_q.size() - base, 32'd2);
        if (ack_id_q.size() - base == 2)
            chk("post_rst_first", ack_id_q[base], 32'd0);
        chk("post_rst_rdata0", bus.rdata0, 32'd4);
        chk("post_rst_rdata1", bus.rdata1, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
